lif_neuron_scheduler: RTL
=========================

# lif_neuron_scheduler

Time-multiplexed controller that shares one leaky integrate-and-fire update datapath among NUM_NEURONS virtual neurons. Per-neuron membrane potential, pending-input and refractory state live in local registers. A round-robin slot pointer selects one neuron per enabled cycle and applies integrate, leak, fire and reset to it. Sits between the user input pins and the spike LEDs, replacing one-accumulator-per-neuron instantiation.

## Interface
Parameters:
- NUM_NEURONS, 4, number of virtual neurons (power of two, 2..16)
- WIDTH, 8, membrane potential width
- THRESH, 100, fire threshold (compare is `v >= THRESH`)
- ADD, 5, increment applied when the serviced neuron has input
- LEAK, 1, decrement applied when the serviced neuron has no input
- VRESET, 0, potential loaded after a fire
- REFRAC, 3, refractory length in services (used only with LIF_REFRACTORY_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  when high, the scheduler advances and services one neuron per cycle
- spike_in  in  NUM_NEURONS  per-neuron input event, level-sampled every cycle
- spike_out  out  NUM_NEURONS  registered one-cycle fire pulse, one bit per neuron
- spike_any  out  1  OR of spike_out, registered together with it
- slot  out  $clog2(NUM_NEURONS)  index of the neuron serviced in the current cycle
- slot_v  out  WIDTH  registered post-update potential of the neuron serviced last cycle

## Operation
- Pending capture, every cycle regardless of en: `pending[i] <= pending[i] | spike_in[i]`, except when neuron i is serviced.
- Service of neuron i = slot, only when en=1:
  - `in_eff = pending[i] | spike_in[i]`. pending[i] is cleared at that edge.
  - A spike_in[i] high in the service cycle is consumed and not left pending.
- Update rules, evaluated in this order:
  1. Refractory (macro on): if `refr[i] != 0`, then `refr[i] -= 1`, v[i] is held at VRESET, in_eff is discarded, and no fire occurs.
  2. If in_eff: `v_next = min(v + ADD, 2^WIDTH-1)`. This is a saturating add.
  3. Otherwise: `v_next = (v > LEAK) ? v - LEAK : 0`. The floor is 0.
  4. If `v_next >= THRESH`: fire. spike_out[i] pulses, v[i] <= VRESET, and refr[i] <= REFRAC (macro on).
  5. Otherwise: v[i] <= v_next.
- Slot pointer: increments modulo NUM_NEURONS on each enabled cycle and wraps from NUM_NEURONS-1 to 0. It holds while en=0.
- en=0: there are no services. v and refr are frozen, spike_out is 0, and pending capture continues.
- Reset values:
  - v[*]=VRESET, refr[*]=0, pending=0
  - slot=0, spike_out=0, spike_any=0, slot_v=0

## Timing
- Service latency: the neuron serviced in cycle t has its v, refr and pending registers updated at the end of cycle t.
  - spike_out[i] and spike_any are high during cycle t+1 only.
  - slot_v holds the cycle-t result during cycle t+1.
- Service period: each neuron is serviced exactly once per NUM_NEURONS enabled cycles. At most one spike_out bit is high per cycle.
- First service after rst deasserts (with en=1) goes to neuron 0. Neuron k is serviced in cycles k, k+N, k+2N, and so on.
- An input pulse of any width (≥1 cycle) is never lost. Multiple pulses between two services of the same neuron count as one event.
- rst asserted mid-operation overrides everything in that cycle, including a service and a pending capture. There is no fire pulse in the following cycle.

## Configuration
- LIF_REFRACTORY_EN defined: a per-neuron refractory counter of $clog2(REFRAC+1) bits is built. It gives REFRAC dead services after each fire; inputs arriving in those services are dropped.
- Undefined: no refr storage. A neuron resumes integrating from VRESET on its very next service.

## Structure
- Shared package lif_pkg: default constants LIF_WIDTH, LIF_THRESH, LIF_ADD, LIF_LEAK, LIF_VRESET, LIF_REFRAC, and the typedef for the membrane word.
- One natural sub-module, lif_update_unit: the combinational saturating add/leak/threshold compare for a single neuron. Inputs are v, in_eff and refr_busy; outputs are v_next and fire. It is instantiated once and muxed by slot.
- The scheduler owns the state arrays, the pointer, pending capture and the output registers.

## Test plan
All cases use defaults: N=4, ADD=5, LEAK=1, THRESH=100, VRESET=0, REFRAC=3, en=1.
- **Threshold fire:** spike_in[0] held high from reset. v[0] climbs 5,10,…,100. The 20th service is at cycle 76, so spike_out[0] and spike_any are high in cycle 77 only, and the next slot_v for neuron 0 is 0.
- **Refractory (macro on):** continue the previous case. Services at cycles 80, 84 and 88 leave v[0]=0. The cycle-92 service gives v[0]=5. With the macro off, the cycle-80 service already gives 5.
- **Pending capture:** a one-cycle spike_in[2] pulse in cycle 0 is serviced in cycle 2, giving slot_v=5 in cycle 3. Later services with no input leak it 4,3,2,1,0,0.
- **Saturation (THRESH=255, ADD=100):** held input gives v=100,200,255, then fires at the 255 service. There is no wrap.
- **en gating:** en=0 for cycles 5–9 while spike_in[1] is pulsed in cycle 6. slot holds at 1 and there are no spike_out pulses. On resume, neuron 1 is serviced first and its potential is +5.
- **Reset mid-operation:** assert rst in the cycle neuron 0 would reach 100. spike_out stays 0 in the next cycle, all v are 0, and slot=0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and types for the leaky integrate-and-fire neuron scheduler.
// Optional feature macro: LIF_REFRACTORY_EN (per-neuron refractory counters).
package lif_pkg;

  localparam int LIF_NUM_NEURONS = 4;
  localparam int LIF_WIDTH       = 8;
  localparam int LIF_THRESH      = 100;
  localparam int LIF_ADD         = 5;
  localparam int LIF_LEAK        = 1;
  localparam int LIF_VRESET      = 0;
  localparam int LIF_REFRAC      = 3;

  // Membrane potential word at the default width.
  typedef logic [LIF_WIDTH-1:0] lif_v_t;

  // Counter width able to hold 0..refrac; never narrower than one bit.
  function automatic int lif_refr_width(input int refrac);
    if (refrac > 32'sd0) begin
      return $clog2(refrac + 32'sd1);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational LIF update for a single neuron: saturating integrate,
// floored leak, threshold compare and post-fire reset value.
// Refractory suppression arrives as refr_busy (driven only with LIF_REFRACTORY_EN).
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int WIDTH  = LIF_WIDTH,
  parameter int THRESH = LIF_THRESH,
  parameter int ADD    = LIF_ADD,
  parameter int LEAK   = LIF_LEAK,
  parameter int VRESET = LIF_VRESET
) (
  input  logic [WIDTH-1:0] v,
  input  logic             in_eff,
  input  logic             refr_busy,
  output logic [WIDTH-1:0] v_next,
  output logic             fire
);

  localparam logic [WIDTH:0]   add_c    = (WIDTH+1)'(ADD);
  localparam logic [WIDTH:0]   thresh_c = (WIDTH+1)'(THRESH);
  localparam logic [WIDTH-1:0] leak_c   = WIDTH'(LEAK);
  localparam logic [WIDTH-1:0] vreset_c = WIDTH'(VRESET);
  localparam logic [WIDTH-1:0] max_c    = {WIDTH{1'b1}};

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] cand_s;

  // Candidate potential (integrate or leak), then refractory/fire resolution.
  always_comb begin
    sum_s  = {1'b0, v} + add_c;
    cand_s = v;
    v_next = v;
    fire   = 1'b0;

    if (in_eff) begin
      if (sum_s[WIDTH]) begin
        cand_s = max_c;
      end else begin
        cand_s = sum_s[WIDTH-1:0];
      end
    end else begin
      if (v > leak_c) begin
        cand_s = v - leak_c;
      end else begin
        cand_s = {WIDTH{1'b0}};
      end
    end

    if (refr_busy) begin
      v_next = vreset_c;
      fire   = 1'b0;
    end else if ({1'b0, cand_s} >= thresh_c) begin
      v_next = vreset_c;
      fire   = 1'b1;
    end else begin
      v_next = cand_s;
      fire   = 1'b0;
    end
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed LIF controller: one shared update unit serves NUM_NEURONS
// virtual neurons in round-robin order, one per enabled cycle.
// Optional feature macro: LIF_REFRACTORY_EN adds per-neuron refractory counters
// and the REFRAC parameter.
module lif_neuron_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = LIF_NUM_NEURONS,
  parameter int WIDTH       = LIF_WIDTH,
  parameter int THRESH      = LIF_THRESH,
  parameter int ADD         = LIF_ADD,
  parameter int LEAK        = LIF_LEAK,
  parameter int VRESET      = LIF_VRESET
`ifdef LIF_REFRACTORY_EN
  ,
  parameter int REFRAC      = LIF_REFRAC
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_NEURONS-1:0]         spike_in,
  output logic [NUM_NEURONS-1:0]         spike_out,
  output logic                           spike_any,
  output logic [$clog2(NUM_NEURONS)-1:0] slot,
  output logic [WIDTH-1:0]               slot_v
);

  localparam int SLOT_W = $clog2(NUM_NEURONS);
  localparam logic [WIDTH-1:0] vreset_c = WIDTH'(VRESET);

  logic [WIDTH-1:0]       v_r [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] pending_r;
  logic [SLOT_W-1:0]      slot_r;
  logic [NUM_NEURONS-1:0] spike_out_r;
  logic                   spike_any_r;
  logic [WIDTH-1:0]       slot_v_r;

  logic [WIDTH-1:0]       v_cur_s;
  logic [WIDTH-1:0]       v_next_s;
  logic                   in_eff_s;
  logic                   refr_busy_s;
  logic                   fire_s;
  logic [NUM_NEURONS-1:0] pending_next_s;
  logic [NUM_NEURONS-1:0] fire_vec_s;

`ifdef LIF_REFRACTORY_EN
  localparam int REFR_W = lif_refr_width(REFRAC);
  localparam logic [REFR_W-1:0] refrac_c = REFR_W'(REFRAC);

  logic [REFR_W-1:0] refr_r [NUM_NEURONS];

  // Refractory state of the serviced neuron.
  always_comb begin
    refr_busy_s = (refr_r[slot_r] != {REFR_W{1'b0}});
  end

  // Refractory counters: count down while busy, reload on a fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        refr_r[i] <= {REFR_W{1'b0}};
      end
    end else if (en) begin
      if (refr_busy_s) begin
        refr_r[slot_r] <= refr_r[slot_r] - REFR_W'(1);
      end else if (fire_s) begin
        refr_r[slot_r] <= refrac_c;
      end
    end
  end
`else
  // Without refractory storage a neuron is never held off.
  always_comb begin
    refr_busy_s = 1'b0;
  end
`endif

  // Select the serviced neuron's potential and effective input.
  always_comb begin
    v_cur_s  = v_r[slot_r];
    in_eff_s = pending_r[slot_r] | spike_in[slot_r];
  end

  lif_update_unit #(
    .WIDTH  (WIDTH),
    .THRESH (THRESH),
    .ADD    (ADD),
    .LEAK   (LEAK),
    .VRESET (VRESET)
  ) u_update (
    .v         (v_cur_s),
    .in_eff    (in_eff_s),
    .refr_busy (refr_busy_s),
    .v_next    (v_next_s),
    .fire      (fire_s)
  );

  // Pending capture for all neurons; the serviced one consumes its event.
  always_comb begin
    pending_next_s = pending_r | spike_in;
    fire_vec_s     = {NUM_NEURONS{1'b0}};
    if (en) begin
      pending_next_s[slot_r] = 1'b0;
      fire_vec_s[slot_r]     = fire_s;
    end else begin
      pending_next_s = pending_r | spike_in;
      fire_vec_s     = {NUM_NEURONS{1'b0}};
    end
  end

  // Neuron state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_r[i] <= vreset_c;
      end
      pending_r <= {NUM_NEURONS{1'b0}};
      slot_r    <= {SLOT_W{1'b0}};
    end else begin
      pending_r <= pending_next_s;
      if (en) begin
        v_r[slot_r] <= v_next_s;
        slot_r      <= slot_r + SLOT_W'(1);
      end
    end
  end

  // Registered fire pulse and last service result.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_out_r <= {NUM_NEURONS{1'b0}};
      spike_any_r <= 1'b0;
      slot_v_r    <= {WIDTH{1'b0}};
    end else begin
      spike_out_r <= fire_vec_s;
      spike_any_r <= |fire_vec_s;
      if (en) begin
        slot_v_r <= v_next_s;
      end
    end
  end

  assign spike_out = spike_out_r;
  assign spike_any = spike_any_r;
  assign slot      = slot_r;
  assign slot_v    = slot_v_r;

endmodule
